sram_1p_march_bist: RTL and testbench
=====================================

SRAM_1P_MARCH_BIST -- requirements
Module: sram_1p_march_bist

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 64: macro data width.
REQ-002 SHALL have parameter P_ADDR_WIDTH, default 10: macro address width.
REQ-003 SHALL have parameter P_DEPTH, default 2**P_ADDR_WIDTH: words tested, 2..2**P_ADDR_WIDTH; non-power-of-2 allowed.
REQ-004 SHALL have parameter P_RD_LAT, default 1: cycles from read-issue edge to A_DOUT sampled for compare, 1..3.
REQ-005 SHALL use one clock and a synchronous, active-high reset; all logic on posedge A_CLK.
REQ-006 Ports, one per line (name  direction  width  meaning):
  A_CLK  in  1  clock, shared with macro BIST clock
  A_RST  in  1  synchronous active-high reset
  A_START  in  1  start pulse, honoured only in IDLE
  A_ABORT  in  1  abort request, honoured in any non-IDLE state
  A_DOUT  in  P_DATA_WIDTH  macro read data
  A_BIST_EN  out  1  selects macro BIST port; high from RUN entry to DONE exit
  A_BIST_MEN  out  1  macro enable for current op
  A_BIST_WEN  out  1  write strobe
  A_BIST_REN  out  1  read strobe
  A_BIST_ADDR  out  P_ADDR_WIDTH  op address
  A_BIST_DIN  out  P_DATA_WIDTH  write data, all-0 or all-1
  A_BIST_BM  out  P_DATA_WIDTH  bit mask, all-1 during writes, 0 otherwise
  A_BUSY  out  1  high in RUN and DRAIN
  A_DONE  out  1  one-cycle pulse at test end
  A_PASS  out  1  level; valid from DONE until next START
  A_FAIL_ADDR  out  P_ADDR_WIDTH  address of first miscompare
  A_FAIL_CNT  out  16  miscompare count, saturates at 16'hFFFF
  A_FAIL_BITS  out  P_DATA_WIDTH  OR of all miscompare bit vectors

Function
REQ-007 SHALL run March C-: E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-008 SHALL issue exactly one op per cycle; MEN=1 with exactly one of WEN/REN; r-then-w on same address in consecutive cycles.
REQ-009 Up elements SHALL count 0..P_DEPTH-1, down elements P_DEPTH-1..0; no address >= P_DEPTH ever issued.
REQ-010 States IDLE, RUN, DRAIN, DONE; IDLE->RUN on A_START; RUN->DRAIN after last E5 read; DRAIN->DONE after P_RD_LAT cycles; DONE->IDLE after one cycle.
REQ-011 START sampled at edge k: first op driven from k+1, last op at k+10*P_DEPTH, A_DONE high in cycle k+10*P_DEPTH+P_RD_LAT+1.
REQ-012 Expected data SHALL travel in a P_RD_LAT-deep pipeline beside each read; A_DOUT compared only when the matching valid bit emerges.
REQ-013 On miscompare: A_FAIL_CNT increments (saturating), A_FAIL_BITS |= A_DOUT^expected, A_FAIL_ADDR loaded only on first miscompare.
REQ-014 A_PASS SHALL be 1 at DONE iff A_FAIL_CNT==0; fail registers cleared at START, held otherwise.
REQ-015 A_START outside IDLE SHALL be ignored; A_START and A_ABORT together in IDLE: START wins.
REQ-016 A_ABORT SHALL, next cycle, go IDLE, drop A_BIST_EN/MEN/WEN/REN, flush compare pipeline, no A_DONE, A_PASS=0.
REQ-017 Outside RUN, MEN/WEN/REN/BM SHALL be 0; ADDR/DIN hold last value.

Reset
REQ-018 A_RST at any time SHALL, on that edge, force IDLE, all outputs 0 (A_PASS=0, A_FAIL_*=0), pipeline valid bits cleared.

Structure
REQ-019 March element encoding, op enum (OP_R0/OP_R1/OP_W0/OP_W1) and FSM state enum SHALL live in shared package sram_bist_pkg.
REQ-020 Compare pipeline plus fail accumulation SHALL be one sub-module, sram_bist_cmp; address/element sequencing stays in top.

Verification
REQ-021 P_DEPTH=16, P_DATA_WIDTH=8, P_RD_LAT=1, ideal memory model; START at edge 0 -> DONE at cycle 162, PASS=1, FAIL_CNT=0.
REQ-022 Same, bit 3 of addr 5 stuck-at-0 -> PASS=0, FAIL_ADDR=5, FAIL_BITS=8'h08, FAIL_CNT=2 (E2 r1, E4 r1).
REQ-023 P_DEPTH=12, P_ADDR_WIDTH=4, P_RD_LAT=2 -> max ADDR issued 11, DONE at cycle 123, PASS=1.
REQ-024 ABORT at cycle 40 -> cycle 41 BIST_EN=0, BUSY=0, no DONE; new START then completes with PASS=1.
REQ-025 START repeated at cycle 50 during RUN -> ignored, DONE still at cycle 162; A_RST at cycle 60 -> all outputs 0 at cycle 61.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared March C- definitions for the single-port SRAM BIST: FSM states,
// march op codes and the element table (op per phase, direction, length).
// Latency: n/a (types and pure functions only). Backpressure: n/a.
//
// Contents:
//   state_e  : BIST controller states
//   op_e     : march op, bit1 = write, bit0 = data value (read expect / write data)
//   elem_e   : March C- element index E0..E5
//   elem_op / elem_last_ph / elem_up / op_is_wr / op_data : element table helpers
package sram_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Encoding chosen so bit1 is the write flag and bit0 the data value.
   typedef enum logic [1:0] {
      OP_R0 = 2'b00,
      OP_R1 = 2'b01,
      OP_W0 = 2'b10,
      OP_W1 = 2'b11
   } op_e;

   // E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0)
   typedef enum logic [2:0] {
      EL_E0 = 3'd0,
      EL_E1 = 3'd1,
      EL_E2 = 3'd2,
      EL_E3 = 3'd3,
      EL_E4 = 3'd4,
      EL_E5 = 3'd5
   } elem_e;

   // Op issued by element e in phase ph (ph=0 first op, ph=1 second op).
   function automatic op_e elem_op(input elem_e e, input logic ph);
      op_e op;
      case (e)
         EL_E0:        op = OP_W0;
         EL_E1, EL_E3: op = ph ? OP_W1 : OP_R0;
         EL_E2, EL_E4: op = ph ? OP_W0 : OP_R1;
         default:      op = OP_R0;
      endcase
      return op;
   endfunction

   // Phase index of the last op of an element (single-op elements end at 0).
   function automatic logic elem_last_ph(input elem_e e);
      return !((e == EL_E0) || (e == EL_E5));
   endfunction

   // Address direction: 1 = ascending, 0 = descending.
   function automatic logic elem_up(input elem_e e);
      return !((e == EL_E3) || (e == EL_E4));
   endfunction

   function automatic logic op_is_wr(input op_e op);
      return op[1];
   endfunction

   function automatic logic op_data(input op_e op);
      return op[0];
   endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// Read-compare pipeline and fail accumulation for the March BIST.
// Latency: a read issued at edge c is compared against i_dout at edge c+P_RD_LAT.
// Backpressure: none; one read accepted per cycle, i_flush drops reads in flight.
//
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_clear             : clear fail accumulators (test start)
//   i_flush             : drop all reads in flight (abort)
//   i_rd_vld/exp/addr   : read issued this cycle, its expected bit and address
//   i_dout              : macro read data
//   o_fail_addr/cnt/bits: first failing address, saturating count, OR of fail bits
//   o_clean_nxt         : fail count will be zero after this edge
module sram_bist_cmp
   import sram_bist_pkg::*;
#(
   parameter int P_DATA_WIDTH = 64,
   parameter int P_ADDR_WIDTH = 10,
   parameter int P_RD_LAT     = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_clear,
   input  logic                    i_flush,
   input  logic                    i_rd_vld,
   input  logic                    i_rd_exp,
   input  logic [P_ADDR_WIDTH-1:0] i_rd_addr,
   input  logic [P_DATA_WIDTH-1:0] i_dout,
   output logic [P_ADDR_WIDTH-1:0] o_fail_addr,
   output logic [15:0]             o_fail_cnt,
   output logic [P_DATA_WIDTH-1:0] o_fail_bits,
   output logic                    o_clean_nxt
);

   logic [P_RD_LAT-1:0]                   r_vld;
   logic [P_RD_LAT-1:0]                   r_exp;
   logic [P_RD_LAT-1:0][P_ADDR_WIDTH-1:0] r_adr;

   logic [P_ADDR_WIDTH-1:0] r_fail_addr;
   logic [15:0]             r_fail_cnt;
   logic [P_DATA_WIDTH-1:0] r_fail_bits;

   logic [P_DATA_WIDTH-1:0] w_exp_word;
   logic [P_DATA_WIDTH-1:0] w_diff;
   logic                    w_mis;

   // Oldest stage lines up with the macro output for its read.
   assign w_exp_word = {P_DATA_WIDTH{r_exp[P_RD_LAT-1]}};
   assign w_diff     = i_dout ^ w_exp_word;
   // A compare emerging on the abort edge belongs to the aborted run: drop it.
   assign w_mis      = r_vld[P_RD_LAT-1] && (|w_diff) && !i_flush;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= i_rd_vld;
         for (int i = 1; i < P_RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
      end
   end

   // Payload needs no reset; it is qualified by r_vld.
   always_ff @(posedge i_clk) begin
      r_exp[0] <= i_rd_exp;
      r_adr[0] <= i_rd_addr;
      for (int i = 1; i < P_RD_LAT; i++) begin
         r_exp[i] <= r_exp[i-1];
         r_adr[i] <= r_adr[i-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_fail_addr <= '0;
         r_fail_cnt  <= '0;
         r_fail_bits <= '0;
      end else if (w_mis) begin
         // Count saturates, so zero reliably marks "no miscompare yet".
         if (r_fail_cnt == 16'd0) begin
            r_fail_addr <= r_adr[P_RD_LAT-1];
         end
         if (r_fail_cnt != 16'hFFFF) begin
            r_fail_cnt <= r_fail_cnt + 16'd1;
         end
         r_fail_bits <= r_fail_bits | w_diff;
      end
   end

   assign o_fail_addr = r_fail_addr;
   assign o_fail_cnt  = r_fail_cnt;
   assign o_fail_bits = r_fail_bits;
   // Lets the controller latch PASS on the same edge as the final compare.
   assign o_clean_nxt = (r_fail_cnt == 16'd0) && !w_mis;

endmodule

// File: rtl/sram_1p_march_bist.sv
// March C- BIST controller for a single-port SRAM macro (one op per cycle).
// Latency: START at edge k -> ops k+1..k+10*P_DEPTH, A_DONE in cycle k+10*P_DEPTH+P_RD_LAT+1.
// Backpressure: none; A_START ignored while busy, A_ABORT returns to IDLE next cycle.
//
// Ports:
//   A_CLK, A_RST              : clock, synchronous active-high reset
//   A_START, A_ABORT          : start pulse (IDLE only), abort (any non-IDLE state)
//   A_DOUT                    : macro read data
//   A_BIST_EN/MEN/WEN/REN     : macro BIST port select, enable and strobes
//   A_BIST_ADDR/DIN/BM        : op address, write data, write bit mask
//   A_BUSY, A_DONE, A_PASS    : status (RUN|DRAIN), end pulse, pass level
//   A_FAIL_ADDR/CNT/BITS      : first failing address, miscompare count, failing bits
module sram_1p_march_bist
   import sram_bist_pkg::*;
#(
   parameter int P_DATA_WIDTH = 64,
   parameter int P_ADDR_WIDTH = 10,
   parameter int P_DEPTH      = 2**P_ADDR_WIDTH,
   parameter int P_RD_LAT     = 1
) (
   input  logic                    A_CLK,
   input  logic                    A_RST,
   input  logic                    A_START,
   input  logic                    A_ABORT,
   input  logic [P_DATA_WIDTH-1:0] A_DOUT,
   output logic                    A_BIST_EN,
   output logic                    A_BIST_MEN,
   output logic                    A_BIST_WEN,
   output logic                    A_BIST_REN,
   output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
   output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
   output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
   output logic                    A_BUSY,
   output logic                    A_DONE,
   output logic                    A_PASS,
   output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
   output logic [15:0]             A_FAIL_CNT,
   output logic [P_DATA_WIDTH-1:0] A_FAIL_BITS
);

   localparam logic [P_ADDR_WIDTH-1:0] LP_LAST  = P_ADDR_WIDTH'(P_DEPTH - 1);
   localparam logic [P_ADDR_WIDTH-1:0] LP_ONE   = P_ADDR_WIDTH'(1);
   localparam logic [1:0]              LP_DRAIN = 2'(P_RD_LAT - 1);

   // Sequencer: r_elem/r_ph/r_addr describe the op on the macro port this cycle.
   state_e                  r_state;
   elem_e                   r_elem;
   logic                    r_ph;
   logic [P_ADDR_WIDTH-1:0] r_addr;
   logic [1:0]              r_drain_cnt;
   logic                    r_pass;

   op_e                     w_op;
   elem_e                   w_elem_nxt;
   logic                    w_run;
   logic                    w_wr;
   logic                    w_start;
   logic                    w_abort;
   logic                    w_at_end_addr;
   logic                    w_rd_issue;
   logic                    w_clean_nxt;

   assign w_op       = elem_op(r_elem, r_ph);
   assign w_elem_nxt = elem_e'(r_elem + 3'd1);
   assign w_run      = (r_state == ST_RUN);
   assign w_wr       = op_is_wr(w_op);
   assign w_start    = (r_state == ST_IDLE) && A_START;
   // In IDLE, START wins over ABORT because abort is not honoured there at all.
   assign w_abort    = (r_state != ST_IDLE) && A_ABORT;

   // Last address of the current element in its own direction.
   assign w_at_end_addr = elem_up(r_elem) ? (r_addr == LP_LAST) : (r_addr == '0);

   // A read on the abort edge is dropped inside the compare block by i_flush.
   assign w_rd_issue = w_run && !w_wr;

   always_ff @(posedge A_CLK) begin
      if (A_RST) begin
         r_state     <= ST_IDLE;
         r_elem      <= EL_E0;
         r_ph        <= 1'b0;
         r_addr      <= '0;
         r_drain_cnt <= '0;
         r_pass      <= 1'b0;
      end else if (w_start) begin
         r_state <= ST_RUN;
         r_elem  <= EL_E0;
         r_ph    <= 1'b0;
         r_addr  <= '0;
         r_pass  <= 1'b0;
      end else if (w_abort) begin
         // Address and element are left alone so ADDR/DIN hold their last value.
         r_state <= ST_IDLE;
         r_pass  <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (r_ph != elem_last_ph(r_elem)) begin
                  // Read half done; the write to the same address follows.
                  r_ph <= 1'b1;
               end else begin
                  r_ph <= 1'b0;
                  if (w_at_end_addr) begin
                     if (r_elem == EL_E5) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= LP_DRAIN;
                     end else begin
                        r_elem <= w_elem_nxt;
                        r_addr <= elem_up(w_elem_nxt) ? '0 : LP_LAST;
                     end
                  end else if (elem_up(r_elem)) begin
                     r_addr <= r_addr + LP_ONE;
                  end else begin
                     r_addr <= r_addr - LP_ONE;
                  end
               end
            end
            ST_DRAIN: begin
               // Exit on the edge where the last read's compare lands.
               if (r_drain_cnt == 2'd0) begin
                  r_state <= ST_DONE;
                  r_pass  <= w_clean_nxt;
               end else begin
                  r_drain_cnt <= r_drain_cnt - 2'd1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   sram_bist_cmp #(
      .P_DATA_WIDTH (P_DATA_WIDTH),
      .P_ADDR_WIDTH (P_ADDR_WIDTH),
      .P_RD_LAT     (P_RD_LAT)
   ) u_cmp (
      .i_clk       (A_CLK),
      .i_rst       (A_RST),
      .i_clear     (w_start),
      .i_flush     (w_abort),
      .i_rd_vld    (w_rd_issue),
      .i_rd_exp    (op_data(w_op)),
      .i_rd_addr   (r_addr),
      .i_dout      (A_DOUT),
      .o_fail_addr (A_FAIL_ADDR),
      .o_fail_cnt  (A_FAIL_CNT),
      .o_fail_bits (A_FAIL_BITS),
      .o_clean_nxt (w_clean_nxt)
   );

   assign A_BIST_EN   = (r_state != ST_IDLE);
   assign A_BIST_MEN  = w_run;
   assign A_BIST_WEN  = w_run && w_wr;
   assign A_BIST_REN  = w_run && !w_wr;
   assign A_BIST_ADDR = r_addr;
   // Tracks the op data even on reads; the macro ignores it there.
   assign A_BIST_DIN  = {P_DATA_WIDTH{op_data(w_op)}};
   assign A_BIST_BM   = {P_DATA_WIDTH{w_run && w_wr}};
   assign A_BUSY      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign A_DONE      = (r_state == ST_DONE);
   assign A_PASS      = r_pass;

endmodule

// File: tb/tb_sram_1p_march_bist.sv
module tb_sram_1p_march_bist;

   localparam int A_N = 16;
   localparam int B_N = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, a_start, a_abort, b_start;
   logic b_abort = 1'b0;

   // DUT A: 16 words x 8 bits, AW=10, RD_LAT=1
   logic [7:0] a_dout, a_din, a_bm, a_fail_bits;
   logic [9:0] a_addr, a_fail_addr;
   logic [15:0] a_fail_cnt;
   logic a_bist_en, a_men, a_wen, a_ren, a_busy, a_done, a_pass;

   // DUT B: 12 words x 8 bits, AW=4, RD_LAT=2
   logic [7:0] b_dout, b_din, b_bm, b_fail_bits;
   logic [3:0] b_addr, b_fail_addr;
   logic [15:0] b_fail_cnt;
   logic b_bist_en, b_men, b_wen, b_ren, b_busy, b_done, b_pass;

   sram_1p_march_bist #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(10), .P_DEPTH(A_N), .P_RD_LAT(1)) u_dut_a (
      .A_CLK(clk), .A_RST(rst), .A_START(a_start), .A_ABORT(a_abort), .A_DOUT(a_dout),
      .A_BIST_EN(a_bist_en), .A_BIST_MEN(a_men), .A_BIST_WEN(a_wen), .A_BIST_REN(a_ren),
      .A_BIST_ADDR(a_addr), .A_BIST_DIN(a_din), .A_BIST_BM(a_bm), .A_BUSY(a_busy),
      .A_DONE(a_done), .A_PASS(a_pass), .A_FAIL_ADDR(a_fail_addr), .A_FAIL_CNT(a_fail_cnt),
      .A_FAIL_BITS(a_fail_bits));

   sram_1p_march_bist #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(4), .P_DEPTH(B_N), .P_RD_LAT(2)) u_dut_b (
      .A_CLK(clk), .A_RST(rst), .A_START(b_start), .A_ABORT(b_abort), .A_DOUT(b_dout),
      .A_BIST_EN(b_bist_en), .A_BIST_MEN(b_men), .A_BIST_WEN(b_wen), .A_BIST_REN(b_ren),
      .A_BIST_ADDR(b_addr), .A_BIST_DIN(b_din), .A_BIST_BM(b_bm), .A_BUSY(b_busy),
      .A_DONE(b_done), .A_PASS(b_pass), .A_FAIL_ADDR(b_fail_addr), .A_FAIL_CNT(b_fail_cnt),
      .A_FAIL_BITS(b_fail_bits));

   int n_edges = 0;
   always @(posedge clk) n_edges <= n_edges + 1;

   // Memory A: synchronous SRAM, optional stuck-at-0 on bit 3 of word 5.
   bit         stuck = 1'b0;
   logic [7:0] mem_a [0:15];
   logic [7:0] a_wd;
   int         a_oob = 0;
   assign a_wd = (stuck && a_addr == 10'd5) ? (a_din & 8'hF7) : a_din;
   always @(posedge clk) begin
      if (a_men && a_addr >= 10'(A_N)) a_oob <= a_oob + 1;
      if (a_men && a_wen) mem_a[a_addr[3:0]] <= (a_wd & a_bm) | (mem_a[a_addr[3:0]] & ~a_bm);
      if (a_men && a_ren) a_dout <= mem_a[a_addr[3:0]];
   end

   // Memory B: two-cycle read latency, tracks highest issued address.
   logic [7:0] mem_b [0:15];
   logic [7:0] b_q1;
   logic [3:0] max_b = 4'd0;
   int         b_oob = 0;
   always @(posedge clk) begin
      if (b_men && b_addr >= 4'(B_N)) b_oob <= b_oob + 1;
      if (b_men && b_addr > max_b) max_b <= b_addr;
      if (b_men && b_wen) mem_b[b_addr] <= (b_din & b_bm) | (mem_b[b_addr] & ~b_bm);
      if (b_men && b_ren) b_q1 <= mem_b[b_addr];
      b_dout <= b_q1;
   end

   typedef struct {
      int          lat;
      logic        pass;
      logic [15:0] cnt;
      logic [9:0]  addr;
      logic [7:0]  bits;
   } exp_t;
   exp_t sb_q[$];

   int n_chk = 0, n_pass = 0, n_fail = 0, t0 = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_to(input int target);
      while (n_edges < target) tick();
   endtask

   task automatic start_a();
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      t0 = n_edges;
   endtask

   // Expected port op in cycle c (1-based) of a March C- run over n words:
   // {men, wen, ren, addr[9:0], bm[7:0], write data[7:0] (0 on reads)}
   function automatic logic [28:0] exp_op(input int c, input int n);
      int i, e, r, pos, adr;
      logic wr, d;
      i = c - 1;
      if (i < n) begin
         wr = 1'b1; d = 1'b0; adr = i;
      end else if (i < 9 * n) begin
         i   = i - n;
         e   = 1 + i / (2 * n);
         r   = i % (2 * n);
         pos = r / 2;
         wr  = (r % 2) == 1;
         adr = (e <= 2) ? pos : (n - 1 - pos);
         d   = (e == 1 || e == 3) ? wr : !wr;
      end else begin
         wr = 1'b0; d = 1'b0; adr = i - 9 * n;
      end
      return {1'b1, wr, !wr, 10'(adr), (wr ? 8'hFF : 8'h00), ((wr && d) ? 8'hFF : 8'h00)};
   endfunction

   task automatic wait_done(input int sel, input string tag);
      exp_t e;
      bit   seen = 1'b0;
      int   lat;
      for (int i = 0; i < 400; i++) begin
         if ((sel == 0 && a_done === 1'b1) || (sel == 1 && b_done === 1'b1)) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      lat = n_edges - t0;
      e = sb_q.pop_front();
      chk({tag, "_done_seen"}, 64'(seen), 64'd1);
      chk({tag, "_done_lat"}, 64'(lat), 64'(e.lat));
      if (sel == 0) begin
         chk({tag, "_pass"}, 64'(a_pass), 64'(e.pass));
         chk({tag, "_fail_cnt"}, 64'(a_fail_cnt), 64'(e.cnt));
         chk({tag, "_fail_addr"}, 64'(a_fail_addr), 64'(e.addr));
         chk({tag, "_fail_bits"}, 64'(a_fail_bits), 64'(e.bits));
         tick();
         chk({tag, "_after_done"}, 64'({a_done, a_bist_en, a_busy, a_pass}), 64'({3'b000, e.pass}));
      end else begin
         chk({tag, "_pass"}, 64'(b_pass), 64'(e.pass));
         chk({tag, "_fail_cnt"}, 64'(b_fail_cnt), 64'(e.cnt));
         chk({tag, "_fail_addr"}, 64'(b_fail_addr), 64'(e.addr));
         chk({tag, "_fail_bits"}, 64'(b_fail_bits), 64'(e.bits));
         tick();
         chk({tag, "_after_done"}, 64'({b_done, b_bist_en, b_busy, b_pass}), 64'({3'b000, e.pass}));
      end
   endtask

   initial begin
      int ndone;
      rst = 1'b1; a_start = 1'b0; a_abort = 1'b0; b_start = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_ctl", 64'({a_bist_en, a_men, a_wen, a_ren, a_busy, a_done, a_pass}), 64'd0);
      chk("rst_port", 64'({a_addr, a_din, a_bm}), 64'd0);
      chk("rst_fail", 64'({a_fail_addr, a_fail_cnt, a_fail_bits}), 64'd0);
      tick();

      // Fault-free run with full op-sequence check.
      sb_q.push_back('{161, 1'b1, 16'd0, 10'd0, 8'h00});
      start_a();
      chk("t1_en_busy", 64'({a_bist_en, a_busy}), 64'b11);
      for (int c = 1; c <= 10 * A_N; c++) begin
         chk($sformatf("t1_op_c%0d", c),
             64'({a_men, a_wen, a_ren, a_addr, a_bm, (a_wen ? a_din : 8'h00)}),
             64'(exp_op(c, A_N)));
         tick();
      end
      wait_done(0, "t1");

      // Bit 3 of word 5 stuck at 0: caught by E2 r1 and E4 r1.
      stuck = 1'b1;
      sb_q.push_back('{161, 1'b0, 16'd2, 10'd5, 8'h08});
      start_a();
      wait_done(0, "t2");
      repeat (3) tick();
      chk("t2_hold_cnt", 64'(a_fail_cnt), 64'd2);
      stuck = 1'b0;

      // Abort at cycle 40; fail registers were cleared by the start.
      start_a();
      chk("t3_clear_on_start", 64'({a_fail_cnt, a_fail_bits, a_fail_addr}), 64'd0);
      wait_to(t0 + 39);
      a_abort = 1'b1;
      tick();
      a_abort = 1'b0;
      chk("t3_abort_ctl", 64'({a_bist_en, a_busy, a_men, a_wen, a_ren, a_bm, a_pass}), 64'd0);
      ndone = 0;
      for (int i = 0; i < 200; i++) begin
         if (a_done === 1'b1) ndone++;
         tick();
      end
      chk("t3_no_done", 64'(ndone), 64'd0);
      sb_q.push_back('{161, 1'b1, 16'd0, 10'd0, 8'h00});
      start_a();
      wait_done(0, "t3r");

      // START repeated mid-run is ignored.
      sb_q.push_back('{161, 1'b1, 16'd0, 10'd0, 8'h00});
      start_a();
      wait_to(t0 + 49);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      chk("t4_busy", 64'(a_busy), 64'd1);
      wait_done(0, "t4");

      // Reset at cycle 60 of a faulty run: compare landing on that edge is lost.
      stuck = 1'b1;
      start_a();
      wait_to(t0 + 59);
      chk("t5_busy_pre", 64'({a_busy, a_bist_en}), 64'b11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_ctl", 64'({a_bist_en, a_men, a_wen, a_ren, a_busy, a_done, a_pass}), 64'd0);
      chk("t5_rst_port", 64'({a_addr, a_din, a_bm}), 64'd0);
      chk("t5_rst_fail", 64'({a_fail_addr, a_fail_cnt, a_fail_bits}), 64'd0);
      stuck = 1'b0;
      sb_q.push_back('{161, 1'b1, 16'd0, 10'd0, 8'h00});
      start_a();
      wait_done(0, "t5r");
      chk("a_no_oob", 64'(a_oob), 64'd0);

      // Non-power-of-2 depth with two-cycle read latency.
      sb_q.push_back('{122, 1'b1, 16'd0, 10'd0, 8'h00});
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      t0 = n_edges;
      wait_done(1, "t6");
      chk("t6_max_addr", 64'(max_b), 64'd11);
      chk("t6_no_oob", 64'(b_oob), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
